// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: transfer sizes and
// the size-to-byte-enable helper used by the BIU.
package biu_constants_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } biu_size_t;

  function automatic logic [3:0] size2be(
    input biu_size_t  size,
    input logic [1:0] adr
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      BYTE:    be = 4'b0001 << adr;
      HWORD:   be = 4'b0011 << adr;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_rsp_ram.sv
// Single-port data RAM: synchronous read with enable,
// per-byte write enables. Read register holds between reads.
module riscv_dmem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              re,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [AW-1:0]     adr,
  input  logic [XLEN-1:0]   d,
  output logic [XLEN-1:0]   q
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < XLEN/8; i++) begin
      if (we && be[i]) begin
        mem[adr][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= '0;
    end else if (re) begin
      q <= mem[adr];
    end
  end

endmodule

// File: rtl/dmem_rsp.sv
// Data-memory responder: captures a request, waits a fixed
// number of cycles, then terminates with ack, err or misaligned.
module dmem_rsp
  import biu_constants_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] BASE        = 'h0000_0000,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN:0] LIMIT =
    {1'b0, BASE} + (XLEN+1)'(DEPTH*4);
  localparam logic [3:0] CNT_INIT =
    4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, nxt;
  logic [3:0] cnt;

  logic [XLEN-1:0] adr_q, d_q;
  logic            we_q;
  biu_size_t       size_q;

  logic [XLEN-1:0] sel_adr, off;
  logic            sel_we;
  biu_size_t       sel_size;
  logic            mis, err, ok, go_resp;

  logic            ram_re, ram_we;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_adr;

  // In IDLE the live request feeds the RAM so a zero-wait read
  // lands in the read register by the response cycle.
  always_comb begin
    sel_adr  = adr_q;
    sel_we   = we_q;
    sel_size = size_q;
    if (state == IDLE) begin
      sel_adr  = dmem_adr;
      sel_we   = dmem_we;
      sel_size = dmem_size;
    end
  end

  always_comb begin
    mis = (sel_size == HWORD && sel_adr[0]) ||
          (sel_size == WORD && sel_adr[1:0] != 2'b00);
    err = ({1'b0, sel_adr} < {1'b0, BASE}) ||
          ({1'b0, sel_adr} >= LIMIT) ||
          (sel_size == DWORD);
    ok  = !mis && !err;
    off = sel_adr - BASE;
  end

  assign go_resp = (state == IDLE && dmem_req &&
                    WAIT_STATES == 0) ||
                   (state == WAIT && cnt == 4'd0);

  assign ram_re  = go_resp && !sel_we && ok;
  assign ram_we  = (state == RESP) && we_q && ok;
  assign ram_be  = size2be(sel_size, sel_adr[1:0]);
  assign ram_adr = AW'(off >> 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (dmem_req) begin
        nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt == 4'd0) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_ack        = 1'b0;
    dmem_err        = 1'b0;
    dmem_misaligned = 1'b0;
    if (state == RESP) begin
      dmem_misaligned = mis;
      dmem_err        = !mis && err;
      dmem_ack        = ok;
    end
  end

  assign dmem_page_fault = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= 4'd0;
      adr_q  <= '0;
      d_q    <= '0;
      we_q   <= 1'b0;
      size_q <= BYTE;
    end else if (state == IDLE && dmem_req) begin
      cnt    <= CNT_INIT;
      adr_q  <= dmem_adr;
      d_q    <= dmem_d;
      we_q   <= dmem_we;
      size_q <= dmem_size;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  riscv_dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .re     (ram_re),
    .we     (ram_we),
    .be     (ram_be),
    .adr    (ram_adr),
    .d      (d_q),
    .q      (dmem_q)
  );

endmodule

// File: tb/tb_dmem_rsp.sv
// Scoreboard bench for dmem_rsp at zero and three wait states.
module tb_dmem_rsp;
  import biu_constants_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] d = '0;
  biu_size_t   size = BYTE;

  logic [31:0] q0, q3;
  logic ack0, err0, mis0, pf0;
  logic ack3, err3, mis3, pf3;

  dmem_rsp #(.WAIT_STATES(0)) u_dut0 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dmem_req        (req0),
    .dmem_adr        (adr),
    .dmem_d          (d),
    .dmem_we         (we),
    .dmem_size       (size),
    .dmem_q          (q0),
    .dmem_ack        (ack0),
    .dmem_err        (err0),
    .dmem_misaligned (mis0),
    .dmem_page_fault (pf0)
  );

  dmem_rsp #(.WAIT_STATES(3)) u_dut3 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dmem_req        (req3),
    .dmem_adr        (adr),
    .dmem_d          (d),
    .dmem_we         (we),
    .dmem_size       (size),
    .dmem_q          (q3),
    .dmem_ack        (ack3),
    .dmem_err        (err3),
    .dmem_misaligned (mis3),
    .dmem_page_fault (pf3)
  );

  typedef struct {
    int          ws;
    logic [2:0]  rsp;
    logic [31:0] q;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] last_q0 = '0;
  logic [31:0] last_q3 = '0;

  localparam logic [2:0] ACK = 3'b100;
  localparam logic [2:0] ERR = 3'b010;
  localparam logic [2:0] MIS = 3'b001;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int ws,
                      input logic [31:0] a,
                      input logic [31:0] dd,
                      input logic w,
                      input biu_size_t s,
                      input logic [2:0] rsp,
                      input logic [31:0] rq,
                      input string tag);
    exp_t e;
    int n;
    logic [2:0] got;
    logic [31:0] gq;
    e.ws  = ws;
    e.rsp = rsp;
    if (rsp == ACK && !w) e.q = rq;
    else e.q = (ws == 0) ? last_q0 : last_q3;
    sb.push_back(e);
    @(negedge clk);
    adr = a; d = dd; we = w; size = s;
    if (ws == 0) req0 = 1'b1;
    else req3 = 1'b1;
    @(posedge clk);
    #1;
    // scramble fields and drop req: captured values must govern
    adr = 32'h0000_0000; d = 32'hFFFF_FFFF;
    we = ~w; size = BYTE;
    req0 = 1'b0; req3 = 1'b0;
    n = 0; got = '0; gq = '0;
    while (got == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
      got = (ws == 0) ? {ack0, err0, mis0} : {ack3, err3, mis3};
      gq  = (ws == 0) ? q0 : q3;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(n), 32'(e.ws + 1));
    chk({tag, " rsp"}, 32'(got), 32'(e.rsp));
    chk({tag, " q"}, gq, e.q);
    if (ws == 0) last_q0 = e.q;
    else last_q3 = e.q;
    @(negedge clk);
    got = (ws == 0) ? {ack0, err0, mis0} : {ack3, err3, mis3};
    chk({tag, " pulse"}, 32'(got), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst q0", q0, 32'd0);
    chk("rst q3", q3, 32'd0);
    chk("rst out0", 32'({ack0, err0, mis0, pf0}), 32'd0);
    chk("rst out3", 32'({ack3, err3, mis3, pf3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(0, 32'h10, 32'hDEAD_BEEF, 1, WORD, ACK, 0, "w10");
    xfer(0, 32'h10, 32'h0, 0, WORD, ACK, 32'hDEAD_BEEF, "r10");
    xfer(0, 32'h12, 32'h00AB_0000, 1, BYTE, ACK, 0, "wb12");
    xfer(0, 32'h10, 32'h0, 0, WORD, ACK, 32'hDEAB_BEEF, "r10b");
    xfer(0, 32'h11, 32'h0, 0, HWORD, MIS, 0, "rh11");
    xfer(0, 32'h11, 32'hFFFF_FFFF, 1, HWORD, MIS, 0, "wh11");
    xfer(0, 32'h1000, 32'h0, 0, WORD, ERR, 0, "rtop");
    xfer(0, 32'h0, 32'h0, 0, DWORD, ERR, 0, "rdw0");
    xfer(0, 32'h1001, 32'h0, 0, WORD, MIS, 0, "prio");
    xfer(0, 32'h2, 32'h0, 0, DWORD, ERR, 0, "rdw2");
    xfer(0, 32'h10, 32'h1111_1111, 1, DWORD, ERR, 0, "wdw10");
    xfer(0, 32'h10, 32'h0, 0, WORD, ACK, 32'hDEAB_BEEF, "r10c");
    xfer(0, 32'h0, 32'h0102_0304, 1, WORD, ACK, 0, "w0");
    xfer(0, 32'h1000, 32'hAAAA_AAAA, 1, WORD, ERR, 0, "wtop");
    xfer(0, 32'h0, 32'h0, 0, WORD, ACK, 32'h0102_0304, "r0");
    xfer(0, 32'h14, 32'h1122_3344, 1, WORD, ACK, 0, "w14");
    xfer(0, 32'h16, 32'hA5A5_0000, 1, HWORD, ACK, 0, "wh16");
    xfer(0, 32'h14, 32'h0, 0, WORD, ACK, 32'hA5A5_3344, "r14");
    xfer(0, 32'h13, 32'h0, 0, BYTE, ACK, 32'hDEAB_BEEF, "rb13");

    xfer(3, 32'h10, 32'hDEAD_BEEF, 1, WORD, ACK, 0, "ws3 w10");
    xfer(3, 32'h10, 32'h0, 0, WORD, ACK, 32'hDEAD_BEEF, "ws3 r10");
    xfer(3, 32'h2, 32'h0, 0, WORD, MIS, 0, "ws3 mis");
    xfer(3, 32'h20, 32'hCAFE_F00D, 1, WORD, ACK, 0, "ws3 w20");

    // abort a write with reset in its second wait cycle
    @(negedge clk);
    adr = 32'h20; d = 32'h1234_5678; we = 1'b1; size = WORD;
    req3 = 1'b1;
    @(posedge clk);
    #1 req3 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort q3", q3, 32'd0);
    chk("abort out3", 32'({ack3, err3, mis3, pf3}), 32'd0);
    last_q0 = '0;
    last_q3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort quiet", 32'({ack3, err3, mis3}), 32'd0);
    end
    xfer(3, 32'h20, 32'h0, 0, WORD, ACK, 32'hCAFE_F00D, "ws3 r20");
    chk("pf", 32'({pf0, pf3}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
